// File: rtl/mip_pkg.sv
// Shared types, constants and helpers for the MIP 3x3 window filter stage.
package mip_pkg;

    typedef enum logic [1:0] {
        MODE_BYPASS = 2'd0,
        MODE_GRAY   = 2'd1,
        MODE_BLUR   = 2'd2,
        MODE_SOBEL  = 2'd3
    } mip_mode_e;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    localparam int BLUR_MUL   = 57;
    localparam int BLUR_SHIFT = 9;

    function automatic logic [3:0] gray4(input rgb444_t p);
        logic [7:0] s;
        s = 8'd5 * {4'd0, p.r} + 8'd9 * {4'd0, p.g} + 8'd2 * {4'd0, p.b};
        return s[7:4];
    endfunction

endpackage

// File: rtl/mip_line_buffer.sv
// One raster line of RGB444 pixels: simple dual-port, 1-cycle synchronous read,
// a read and write to the same address in one cycle returns the old contents.
module mip_line_buffer
    import mip_pkg::*;
#(
    parameter int WIDTH = 640,
    parameter int AW    = $clog2(WIDTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [11:0]   wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [11:0]   rd_data
);

    rgb444_t mem [WIDTH];

    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
        if (wr_en) begin
            mem[wr_addr] <= rgb444_t'(wr_data);
        end
    end

endmodule

// File: rtl/mip_window_filter.sv
// 3x3 neighbourhood filter (bypass/gray/blur/sobel) on an RGB444 raster stream, 2-cycle latency.
// Build option: define MIP_EDGE_THRESH_EN to binarise the sobel output against EDGE_THRESH.
module mip_window_filter
    import mip_pkg::*;
#(
    parameter int WIDTH       = 640,
    parameter int EDGE_THRESH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  mode,
    input  logic        in_valid,
    input  logic        in_sof,
    input  logic        in_eol,
    input  logic [11:0] in_pixel,
    output logic        out_valid,
    output logic        out_sof,
    output logic        out_eol,
    output logic [11:0] out_pixel
);

    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
    localparam logic [9:0]    ROW_MAX  = 10'd1023;
`ifdef MIP_EDGE_THRESH_EN
    localparam bit THRESH_EN = 1'b1;
`else
    localparam bit THRESH_EN = 1'b0;
`endif

    logic [9:0]    row_q, row_cur;
    logic [CW-1:0] col_q, col_cur;
    mip_mode_e     mode_q, mode_cur;

    always_comb begin
        row_cur  = in_sof ? '0 : row_q;
        col_cur  = in_sof ? '0 : col_q;
        mode_cur = in_sof ? mip_mode_e'(mode) : mode_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_q  <= '0;
            col_q  <= '0;
            mode_q <= MODE_BYPASS;
        end else if (in_valid) begin
            mode_q <= mode_cur;
            if (in_eol || col_cur == COL_LAST) begin
                col_q <= '0;
                row_q <= (row_cur == ROW_MAX) ? row_cur : row_cur + 10'd1;
            end else begin
                col_q <= col_cur + CW'(1);
                row_q <= row_cur;
            end
        end
    end

    logic          v1, sof1, eol1, fwd1;
    rgb444_t       px1;
    logic [9:0]    row1;
    logic [CW-1:0] col1;
    mip_mode_e     mode1;
    logic [11:0]   rd0, rd1, fwd_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1       <= 1'b0;
            sof1     <= 1'b0;
            eol1     <= 1'b0;
            fwd1     <= 1'b0;
            px1      <= '0;
            row1     <= '0;
            col1     <= '0;
            mode1    <= MODE_BYPASS;
            fwd_data <= '0;
        end else begin
            v1   <= in_valid;
            sof1 <= in_valid && in_sof;
            eol1 <= in_valid && in_eol;
            if (in_valid) begin
                px1      <= rgb444_t'(in_pixel);
                row1     <= row_cur;
                col1     <= col_cur;
                mode1    <= mode_cur;
                // back-to-back 1-pixel lines: the older-line write lands on the same edge as this read
                fwd1     <= v1 && (col_cur == col1);
                fwd_data <= rd0;
            end
        end
    end

    mip_line_buffer #(.WIDTH(WIDTH)) u_lb_prev (
        .clk     (clk),
        .wr_en   (in_valid),
        .wr_addr (col_cur),
        .wr_data (in_pixel),
        .rd_en   (in_valid),
        .rd_addr (col_cur),
        .rd_data (rd0)
    );

    mip_line_buffer #(.WIDTH(WIDTH)) u_lb_prev2 (
        .clk     (clk),
        .wr_en   (v1),
        .wr_addr (col1),
        .wr_data (rd0),
        .rd_en   (in_valid),
        .rd_addr (col_cur),
        .rd_data (rd1)
    );

    // index 0 = row r-2, 2 = row r
    rgb444_t [2:0] col_new, win_a, win_b;
    rgb444_t       tap [3][3];

    always_comb begin
        col_new[0] = (row1 < 10'd2) ? '0 : rgb444_t'(fwd1 ? fwd_data : rd1);
        col_new[1] = rgb444_t'(rd0);
        col_new[2] = px1;
        for (int i = 0; i < 3; i++) begin
            tap[i][0] = (col1 < CW'(2)) ? '0 : win_b[i];
            tap[i][1] = win_a[i];
            tap[i][2] = col_new[i];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win_a <= '0;
            win_b <= '0;
        end else if (v1) begin
            win_a <= col_new;
            win_b <= win_a;
        end
    end

    function automatic logic [3:0] blur_ch(input logic [7:0] s);
        logic [15:0] p;
        p = 16'(s) * 16'(BLUR_MUL);
        return p[BLUR_SHIFT +: 4];
    endfunction

    function automatic logic [7:0] wsum(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
        return 8'(a) + {3'd0, b, 1'b0} + 8'(c);
    endfunction

    logic [7:0]        sum_r, sum_g, sum_b, gx_abs, gy_abs, mag;
    logic signed [7:0] gx, gy;
    logic [3:0]        g [3][3];
    logic [3:0]        edge_e, gray_c;
    logic [11:0]       sobel_px, pix_next;

    always_comb begin
        sum_r = '0;
        sum_g = '0;
        sum_b = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                sum_r   = sum_r + 8'(tap[i][j].r);
                sum_g   = sum_g + 8'(tap[i][j].g);
                sum_b   = sum_b + 8'(tap[i][j].b);
                g[i][j] = gray4(tap[i][j]);
            end
        end
        gx     = signed'(wsum(g[0][2], g[1][2], g[2][2]) - wsum(g[0][0], g[1][0], g[2][0]));
        gy     = signed'(wsum(g[2][0], g[2][1], g[2][2]) - wsum(g[0][0], g[0][1], g[0][2]));
        gx_abs = gx[7] ? unsigned'(-gx) : unsigned'(gx);
        gy_abs = gy[7] ? unsigned'(-gy) : unsigned'(gy);
        mag    = gx_abs + gy_abs;
        edge_e = (mag[7:2] > 6'd15) ? 4'd15 : mag[5:2];
        if (THRESH_EN) begin
            sobel_px = ({28'd0, edge_e} >= 32'(EDGE_THRESH)) ? 12'hFFF : 12'h000;
        end else begin
            sobel_px = {3{edge_e}};
        end
        gray_c = gray4(px1);

        case (mode1)
            MODE_BYPASS: pix_next = px1;
            MODE_GRAY:   pix_next = {3{gray_c}};
            MODE_BLUR:   pix_next = {blur_ch(sum_r), blur_ch(sum_g), blur_ch(sum_b)};
            MODE_SOBEL:  pix_next = sobel_px;
            default:     pix_next = px1;
        endcase
        if ((mode1 == MODE_BLUR || mode1 == MODE_SOBEL) && (row1 == '0 || col1 == '0)) begin
            pix_next = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_eol   <= 1'b0;
            out_pixel <= 12'h000;
        end else begin
            out_valid <= v1;
            out_sof   <= sof1;
            out_eol   <= eol1;
            if (v1) begin
                out_pixel <= pix_next;
            end
        end
    end

endmodule

// File: tb/tb_mip_window_filter.sv
// Scoreboard bench for mip_window_filter: a frame-image reference model predicts each output.
module tb_mip_window_filter;

    localparam int WIDTH = 640;
    localparam int ROWS  = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic        in_valid = 1'b0;
    logic        in_sof = 1'b0;
    logic        in_eol = 1'b0;
    logic [11:0] in_pixel = 12'h000;
    logic        out_valid, out_sof, out_eol;
    logic [11:0] out_pixel;

    mip_window_filter #(.WIDTH(WIDTH), .EDGE_THRESH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .in_eol    (in_eol),
        .in_pixel  (in_pixel),
        .out_valid (out_valid),
        .out_sof   (out_sof),
        .out_eol   (out_eol),
        .out_pixel (out_pixel)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] pix;
        logic        sof;
        logic        eol;
        int          cyc;
    } exp_t;

    exp_t sb [$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // reference model: the frame as a 2-D image, positions tracked from sof/eol
    logic [11:0] img [ROWS][WIDTH];
    int m_row = 0, m_col = 0, m_mode = 0;

    function automatic int m_gray(logic [11:0] p);
        return (5 * int'(p[11:8]) + 9 * int'(p[7:4]) + 2 * int'(p[3:0])) / 16;
    endfunction

    function automatic logic [11:0] tapv(int rr, int cc);
        if (rr < 0 || cc < 0) return 12'h000;
        return img[rr][cc];
    endfunction

    function automatic logic [11:0] model_out(int r, int c, int md, logic [11:0] p);
        int kx [3][3] = '{'{-1, 0, 1}, '{-2, 0, 2}, '{-1, 0, 1}};
        int ky [3][3] = '{'{-1, -2, -1}, '{0, 0, 0}, '{1, 2, 1}};
        int sum [3];
        int gx, gy, e, gv;
        int o [3];
        logic [11:0] t;
        if (md == 0) return p;
        if (md == 1) begin
            gv = m_gray(p);
            return {gv[3:0], gv[3:0], gv[3:0]};
        end
        if (r == 0 || c == 0) return 12'h000;
        for (int k = 0; k < 3; k++) sum[k] = 0;
        gx = 0;
        gy = 0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                t = tapv(r - 2 + i, c - 2 + j);
                for (int k = 0; k < 3; k++) sum[k] += int'((t >> (4 * k)) & 12'h00F);
                gx += kx[i][j] * m_gray(t);
                gy += ky[i][j] * m_gray(t);
            end
        end
        if (md == 2) begin
            for (int k = 0; k < 3; k++) o[k] = (sum[k] * 57) / 512;
            return {o[2][3:0], o[1][3:0], o[0][3:0]};
        end
        e = ((gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy)) / 4;
        if (e > 15) e = 15;
`ifdef MIP_EDGE_THRESH_EN
        return (e >= 4) ? 12'hFFF : 12'h000;
`else
        return {e[3:0], e[3:0], e[3:0]};
`endif
    endfunction

    task automatic idle_cycle();
        @(negedge clk);
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_eol   = 1'b0;
        in_pixel = 12'($urandom);
    endtask

    task automatic send(logic [11:0] p, bit sof, bit eol);
        int r, c;
        exp_t e;
        @(negedge clk);
        in_valid = 1'b1;
        in_sof   = sof;
        in_eol   = eol;
        in_pixel = p;
        if (sof) begin
            m_row  = 0;
            m_col  = 0;
            m_mode = int'(mode);
        end
        r = m_row;
        c = m_col;
        if (r < ROWS) img[r][c] = p;
        e.pix = model_out(r, c, m_mode, p);
        e.sof = sof;
        e.eol = eol;
        e.cyc = cyc + 2;
        sb.push_back(e);
        if (eol || c == WIDTH - 1) begin
            m_col = 0;
            if (m_row < 1023) m_row++;
        end else begin
            m_col++;
        end
    endtask

    function automatic logic [11:0] pix_gen(int kind, int r, int c);
        case (kind)
            0:       return 12'(r * WIDTH + c);
            2:       return 12'h888;
            3:       return (c < 320) ? 12'h000 : 12'hFFF;
            4:       return (c % 3 == 0) ? 12'hF00 : (c % 3 == 1) ? 12'hFFF : 12'h000;
            default: return 12'($urandom);
        endcase
    endfunction

    // md_mid >= 0 drives a new mode halfway through; abort_at > 0 stops after that many pixels
    task automatic run_frame(int rows, int len, int md, int kind, int gap, bit use_eol, int md_mid, int abort_at);
        int n = 0;
        mode = 2'(md);
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < len; c++) begin
                if (abort_at > 0 && n == abort_at) begin
                    idle_cycle();
                    return;
                end
                if (md_mid >= 0 && r == rows / 2 && c == 0) mode = 2'(md_mid);
                while ($urandom_range(99) < gap) idle_cycle();
                send(pix_gen(kind, r, c), (r == 0 && c == 0), (use_eol && c == len - 1));
                n++;
            end
        end
        idle_cycle();
    endtask

    task automatic do_reset(int ncyc);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_eol   = 1'b0;
        sb.delete();
        repeat (ncyc) @(negedge clk);
        rst = 1'b1;
    endtask

    always @(posedge clk) begin
        #2;
        if (!rst) begin
            n_vec++;
            if (out_valid !== 1'b0 || out_sof !== 1'b0 || out_eol !== 1'b0 || out_pixel !== 12'h000) begin
                n_err++;
                $display("FAIL reset_state: got valid=%b sof=%b eol=%b pixel=%h, expected 0/0/0/000",
                         out_valid, out_sof, out_eol, out_pixel);
            end
        end else if (out_valid === 1'b1) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_output: got pixel=%h at cycle %0d, expected no output", out_pixel, cyc);
            end else begin
                mon_e = sb.pop_front();
                if (out_pixel !== mon_e.pix || out_sof !== mon_e.sof || out_eol !== mon_e.eol || cyc != mon_e.cyc) begin
                    n_err++;
                    $display("FAIL out_pixel: got pix=%h sof=%b eol=%b cyc=%0d, expected pix=%h sof=%b eol=%b cyc=%0d",
                             out_pixel, out_sof, out_eol, cyc, mon_e.pix, mon_e.sof, mon_e.eol, mon_e.cyc);
                end
            end
        end else begin
            if (out_valid !== 1'b0) begin
                n_vec++;
                n_err++;
                $display("FAIL out_valid_x: got %b, expected 0 or 1", out_valid);
            end
            if (sb.size() > 0 && sb[0].cyc <= cyc) begin
                n_vec++;
                n_err++;
                mon_e = sb.pop_front();
                $display("FAIL missing_output: got none at cycle %0d, expected pix=%h", cyc, mon_e.pix);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at time limit, expected completion");
        $fatal(1, "time limit");
    end

    initial begin
        rst = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;

        run_frame(4, WIDTH, 0, 0, 0, 1'b0, -1, 0);
        run_frame(3, 16, 1, 4, 0, 1'b1, -1, 0);
        run_frame(5, WIDTH, 2, 2, 0, 1'b1, -1, 0);
        run_frame(5, WIDTH, 3, 3, 0, 1'b1, -1, 0);
        run_frame(6, 24, 3, 1, 0, 1'b1, 2, 0);
        run_frame(4, 24, 2, 1, 0, 1'b1, -1, 0);
        run_frame(1, 1, 2, 1, 0, 1'b1, -1, 0);

        repeat (12) begin
            run_frame($urandom_range(8, 1), $urandom_range(24, 1), $urandom_range(3, 0), 1, 50, 1'b1, -1, 0);
        end

        run_frame(6, 20, 2, 1, 50, 1'b1, -1, 37);
        do_reset(3);
        run_frame(5, 1, 3, 1, 50, 1'b1, -1, 0);
        run_frame(5, 12, 2, 1, 50, 1'b1, -1, 0);
        run_frame(5, 12, 3, 1, 50, 1'b1, -1, 0);

        repeat (10) idle_cycle();
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
